// File: rtl/conv3x3_stream_pkg.sv
// Shared types, widths and kernel coefficients for the 3x3 streaming convolution.
package conv_pkg;

  localparam int PIX_W  = 8;
  localparam int ACC_W  = 12;
  localparam int COEF_W = 4;

  typedef logic        [PIX_W-1:0]  pix_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Row-major kernel: K[3*r+c] weights window row r (0 = oldest line), column c (0 = oldest).
  localparam coef_t K [9] = '{4'sd0, -4'sd1, 4'sd0,
                              -4'sd1, 4'sd5, -4'sd1,
                              4'sd0, -4'sd1, 4'sd0};

  // Unsigned pixel times signed coefficient, result in the accumulator width.
  function automatic acc_t mul(input pix_t p, input coef_t k);
    acc_t pe;
    acc_t ke;
    pe = acc_t'({{(ACC_W-PIX_W){1'b0}}, p});
    ke = acc_t'(k);
    return pe * ke;
  endfunction

endpackage

// File: rtl/conv3x3_stream_if.sv
// Pixel-in / result-out bundle between the SPI slave and the convolution engine.
interface conv3x3_stream_if;
  import conv_pkg::*;

  logic frame_clr;
  logic pix_valid;
  pix_t pix_in;
  logic res_valid;
  pix_t res_out;
  logic frame_done;

  modport master (output frame_clr, pix_valid, pix_in,
                  input  res_valid, res_out, frame_done);

  modport slave  (input  frame_clr, pix_valid, pix_in,
                  output res_valid, res_out, frame_done);
endinterface

// File: rtl/conv3x3_stream_line_buf.sv
// One image line of pixel storage; combinational read gives read-before-write at the same address.
module conv_line_buf
  import conv_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  pix_t          wdata_i,
  output pix_t          rdata_o
);

  pix_t mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  // Write the new pixel; contents are never cleared.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution: two line buffers, a 3x3 window and a two-stage kernel pipeline.
// Optional CONV_SAT_EN: clamp the shifted sum to [0,255] instead of wrapping modulo 256.
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int SHIFT = 0
) (
  input logic              CLK,
  input logic              RESET,
  conv3x3_stream_if.slave  bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic          clr;
  logic          accept;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          done_q, done_d;
  logic          wv_q, wv_d;
  pix_t          win_q [3][3];
  pix_t          lb0_rd, lb1_rd;
  acc_t          psum_d [3];
  acc_t          psum_q [3];
  logic          v1_q;
  acc_t          sum_c, shifted_c;
  pix_t          res_d;
  pix_t          res_out_q;
  logic          res_valid_q;

  // A clear on the same edge as a pixel drops that pixel.
  assign clr    = RESET | bus.frame_clr;
  assign accept = bus.pix_valid & ~bus.frame_clr;

  conv_line_buf #(.DEPTH(IMG_W)) u_lb0 (
    .clk_i  (CLK),
    .we_i   (accept),
    .addr_i (col_q),
    .wdata_i(bus.pix_in),
    .rdata_o(lb0_rd)
  );

  conv_line_buf #(.DEPTH(IMG_W)) u_lb1 (
    .clk_i  (CLK),
    .we_i   (accept),
    .addr_i (col_q),
    .wdata_i(lb0_rd),
    .rdata_o(lb1_rd)
  );

  // Raster position, frame-end pulse and window-qualify flag for the accepted pixel.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    done_d = 1'b0;
    wv_d   = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
    if (accept) begin
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        if (row_q == RW'(IMG_H - 1)) begin
          row_d  = '0;
          done_d = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position counters and the pulses derived from them.
  always_ff @(posedge CLK) begin
    if (clr) begin
      col_q  <= '0;
      row_q  <= '0;
      done_q <= 1'b0;
      wv_q   <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      done_q <= done_d;
      wv_q   <= wv_d;
    end
  end

  // Shift the window left and load the new right column from the line buffers and input.
  always_ff @(posedge CLK) begin
    if (clr) begin
      win_q <= '{default: '0};
    end else if (accept) begin
      win_q[0][0] <= win_q[0][1];
      win_q[0][1] <= win_q[0][2];
      win_q[0][2] <= lb1_rd;
      win_q[1][0] <= win_q[1][1];
      win_q[1][1] <= win_q[1][2];
      win_q[1][2] <= lb0_rd;
      win_q[2][0] <= win_q[2][1];
      win_q[2][1] <= win_q[2][2];
      win_q[2][2] <= bus.pix_in;
    end
  end

  // Per-row partial sums of the kernel products.
  always_comb begin
    psum_d[0] = mul(win_q[0][0], K[0]) + mul(win_q[0][1], K[1]) + mul(win_q[0][2], K[2]);
    psum_d[1] = mul(win_q[1][0], K[3]) + mul(win_q[1][1], K[4]) + mul(win_q[1][2], K[5]);
    psum_d[2] = mul(win_q[2][0], K[6]) + mul(win_q[2][1], K[7]) + mul(win_q[2][2], K[8]);
  end

  // Stage 1: register partial sums; the products fold directly into them.
  always_ff @(posedge CLK) begin
    if (clr) begin
      psum_q <= '{default: '0};
      v1_q   <= 1'b0;
    end else begin
      psum_q <= psum_d;
      v1_q   <= wv_q;
    end
  end

  // Total, shift and output formatting.
  always_comb begin
    sum_c     = psum_q[0] + psum_q[1] + psum_q[2];
    shifted_c = sum_c >>> SHIFT;
`ifdef CONV_SAT_EN
    if (shifted_c < 0) begin
      res_d = '0;
    end else if (shifted_c > acc_t'(255)) begin
      res_d = '1;
    end else begin
      res_d = PIX_W'(shifted_c);
    end
`else
    res_d = PIX_W'(shifted_c);
`endif
  end

  // Stage 2: publish the result; res_out holds between strobes.
  always_ff @(posedge CLK) begin
    if (clr) begin
      res_out_q   <= '0;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= v1_q;
      if (v1_q) res_out_q <= res_d;
    end
  end

  assign bus.res_valid  = res_valid_q;
  assign bus.res_out    = res_out_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Scoreboard bench for conv3x3_stream on a 4x4 image with the sharpen kernel.
module tb_conv3x3_stream;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  typedef struct {
    int val;
    int due;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];

  int KT [9] = '{0, -1, 0, -1, 5, -1, 0, -1, 0};

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  conv3x3_stream_if bus();

  conv3x3_stream #(.IMG_W(W), .IMG_H(H), .SHIFT(0)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int golden(input int f[N], input int r, input int c);
    int s;
    s = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        s += KT[dr*3+dc] * f[(r-2+dr)*W + (c-2+dc)];
`ifdef CONV_SAT_EN
    if (s < 0) s = 0;
    else if (s > 255) s = 255;
`else
    s = s & 255;
`endif
    return s;
  endfunction

  // Monitor: every result strobe must match the oldest expectation, in value and arrival cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (bus.res_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected res_valid", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("res_out", int'(bus.res_out), e.val);
        chk("res latency", cyc, e.due);
      end
    end
  end

  // Drives n pixels of frame f from (0,0); called and returns at a negedge with pix_valid low.
  task automatic drive(input int f[N], input int n, input int maxgap, input bit push,
                       input bit use_hand, input int hand[4], input string tag);
    exp_t e;
    int   k;
    int   r;
    int   c;
    int   g;
    k = 0;
    for (int i = 0; i < n; i++) begin
      r = i / W;
      c = i % W;
      bus.pix_valid = 1'b1;
      bus.pix_in    = 8'(f[i]);
      @(negedge CLK);
      bus.pix_valid = 1'b0;
      chk({tag, " frame_done"}, int'(bus.frame_done), (i == N-1) ? 1 : 0);
      if (push && r >= 2 && c >= 2) begin
        e.val = use_hand ? hand[k] : golden(f, r, c);
        e.due = cyc + 2;
        sbq.push_back(e);
        k++;
      end
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      for (int j = 0; j < g; j++) @(negedge CLK);
    end
  endtask

  int fconst[N], f20[N], fimp[N], fctr[N], frnd[N], fstale[N], ffresh[N];
  int nohand[4] = '{0, 0, 0, 0};
  int h_imp[4], h_ctr[4];

  initial begin
    for (int i = 0; i < N; i++) begin
      fconst[i] = 10;
      f20[i]    = 20;
      fimp[i]   = (i == 5) ? 255 : 0;
      fctr[i]   = (i == 5) ? 0 : 255;
      frnd[i]   = int'($urandom_range(0, 255));
      fstale[i] = 200 - i;
      ffresh[i] = int'($urandom_range(0, 255));
    end
`ifdef CONV_SAT_EN
    h_imp = '{255, 0, 0, 0};
    h_ctr = '{0, 255, 255, 255};
`else
    h_imp = '{251, 1, 1, 0};
    h_ctr = '{4, 254, 254, 255};
`endif

    RESET         = 1'b1;
    bus.frame_clr = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    repeat (3) @(negedge CLK);
    chk("reset res_valid", int'(bus.res_valid), 0);
    chk("reset res_out", int'(bus.res_out), 0);
    chk("reset frame_done", int'(bus.frame_done), 0);
    RESET = 1'b0;
    @(negedge CLK);

    // Constant frame, back-to-back pixels.
    drive(fconst, N, 0, 1'b1, 1'b1, '{10, 10, 10, 10}, "const");
    repeat (4) @(negedge CLK);
    chk("const held res_out", int'(bus.res_out), 10);

    // Reset right after a qualifying pixel: its result must never appear.
    drive(f20, 11, 0, 1'b0, 1'b0, nohand, "midreset");
    RESET = 1'b1;
    @(negedge CLK);
    chk("midreset res_valid", int'(bus.res_valid), 0);
    chk("midreset res_out", int'(bus.res_out), 0);
    chk("midreset frame_done", int'(bus.frame_done), 0);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);

    // Counters restarted at (0,0): impulse and inverted-impulse frames.
    drive(fimp, N, 0, 1'b1, 1'b1, h_imp, "impulse");
    repeat (2) @(negedge CLK);
    drive(fctr, N, 1, 1'b1, 1'b1, h_ctr, "center");
    repeat (2) @(negedge CLK);

    // Random frame with idle gaps.
    drive(frnd, N, 3, 1'b1, 1'b0, nohand, "random");
    repeat (3) @(negedge CLK);

    // Partial frame, clear (with a colliding pixel that must be dropped), fresh frame.
    drive(fstale, 9, 0, 1'b1, 1'b0, nohand, "stale");
    bus.frame_clr = 1'b1;
    bus.pix_valid = 1'b1;
    bus.pix_in    = 8'd99;
    @(negedge CLK);
    bus.frame_clr = 1'b0;
    bus.pix_valid = 1'b0;
    chk("clr frame_done", int'(bus.frame_done), 0);
    chk("clr res_out", int'(bus.res_out), 0);
    drive(ffresh, N, 2, 1'b1, 1'b0, nohand, "fresh");

    for (int t = 0; t < 20 && sbq.size() > 0; t++) @(negedge CLK);
    chk("scoreboard drained", sbq.size(), 0);
    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
